inst_mem_responder: RTL and testbench

- Memory-side responder for the CPU instruction-fetch interface: serves each `readM` request with a 16-bit word after a fixed latency and flags it with a one-cycle `inputReady` pulse.
- Backed by an internal word-addressed RAM that a testbench or boot loader preloads through a separate load port.
- Sits between the CPU fetch path and instruction storage; supplies the opcode/func words the control unit decodes.

---
 rtl/inst_mem_responder_if.sv | 19 +
 rtl/inst_mem_responder.sv | 112 +++++++++++
 tb/tb_inst_mem_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_responder_if.sv
// Instruction-fetch handshake between the CPU fetch path (master) and the
// instruction memory responder (slave).
//   readM      : fetch request, level, held until inputReady
//   address    : word address of the fetch
//   data       : fetched word, valid while inputReady=1
//   inputReady : one-cycle response strobe
//   busy       : request outstanding in the responder
interface inst_mem_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] data;
    logic                 inputReady;
    logic                 busy;

    modport master (output readM, address, input data, inputReady, busy);
    modport slave  (input readM, address, output data, inputReady, busy);
endinterface

// File: rtl/inst_mem_responder.sv
// Memory-side responder for instruction fetch. Each accepted readM request
// is answered after LATENCY cycles with a one-cycle inputReady pulse and the
// word from an internal RAM that is preloaded through the load port.
//   clk, reset_n : clock (rising edge), async active-low reset
//   bus          : fetch handshake (readM/address in, data/inputReady/busy out)
//   load_en      : preload write enable (honoured only while idle)
//   load_addr    : preload word index
//   load_data    : preload word
//   req_count    : number of completed responses (wraps)
module inst_mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2    // 1..15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    inst_mem_responder_if.slave    bus,
    input  logic                   load_en,
    input  logic [ADDR_BITS-1:0]   load_addr,
    input  logic [WORD_SIZE-1:0]   load_data,
    output logic [WORD_SIZE-1:0]   req_count
);
    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 ready_q;
    logic                 busy_q;
    logic [WORD_SIZE-1:0] count_q;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0] req_idx;
    logic                 accept;
    logic                 do_load;
    logic                 unused_addr_hi;

    // Upper address bits are dropped: fetches wrap modulo the RAM depth.
    assign req_idx        = bus.address[ADDR_BITS-1:0];
    assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_BITS];

    // A load in IDLE takes priority; a held readM is then taken next cycle.
    assign do_load = (state_q == IDLE) && load_en;
    assign accept  = (state_q == IDLE) && bus.readM && !load_en;

    // RAM keeps its contents across reset. Loads only happen in IDLE, so a
    // fetch in flight can never see its own index rewritten.
    always_ff @(posedge clk) begin
        if (do_load) mem_q[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        idx_q  <= req_idx;
                        cnt_q  <= LAT_M1;
                        busy_q <= 1'b1;
                        if (LATENCY == 1) begin
                            // No wait phase: respond in the very next cycle.
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            data_q  <= mem_q[req_idx];
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    // cnt_q==1 here means the next cycle is cycle t0+LATENCY.
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        data_q  <= mem_q[idx_q];
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    count_q <= count_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.inputReady = ready_q;
    assign bus.busy       = busy_q;
    assign req_count      = count_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_en, ld1_en;
    logic [7:0]  ld_addr, ld1_addr;
    logic [15:0] ld_data, ld1_data;
    logic [15:0] cnt, cnt1;

    inst_mem_responder_if #(.WORD_SIZE(16)) bus  ();
    inst_mem_responder_if #(.WORD_SIZE(16)) bus1 ();

    inst_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data), .req_count(cnt)
    );

    inst_mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1),
        .load_en(ld1_en), .load_addr(ld1_addr), .load_data(ld1_data), .req_count(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        ld;
        logic [7:0]  laddr;
        logic [15:0] ldata;
        logic        rdy;
        logic [15:0] dat;
        logic        bsy;
        logic [15:0] cn;
    } vec_t;

    vec_t tv [26];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t mk(logic rd, logic [15:0] addr, logic ld, logic [7:0] laddr,
                                logic [15:0] ldata, logic rdy, logic [15:0] dat,
                                logic bsy, logic [15:0] cn);
        vec_t v;
        v.rd = rd; v.addr = addr; v.ld = ld; v.laddr = laddr; v.ldata = ldata;
        v.rdy = rdy; v.dat = dat; v.bsy = bsy; v.cn = cn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string nm, input logic rdy, input logic [15:0] dat,
                            input logic bsy, input logic [15:0] cn);
        chk({nm, ".ready"}, 16'(bus.inputReady), 16'(rdy));
        chk({nm, ".data"},  bus.data, dat);
        chk({nm, ".busy"},  16'(bus.busy), 16'(bsy));
        chk({nm, ".count"}, cnt, cn);
    endtask

    task automatic chk_l1(input string nm, input logic rdy, input logic [15:0] dat,
                          input logic bsy, input logic [15:0] cn);
        chk({nm, ".ready"}, 16'(bus1.inputReady), 16'(rdy));
        chk({nm, ".data"},  bus1.data, dat);
        chk({nm, ".busy"},  16'(bus1.busy), 16'(bsy));
        chk({nm, ".count"}, cnt1, cn);
    endtask

    initial begin
        //            rd  addr      ld laddr ldata      rdy dat       bsy cnt
        tv[0]  = mk(0, 16'h0000, 1, 8'h05, 16'hF01C, 0, 16'h0000, 0, 16'd0);
        tv[1]  = mk(0, 16'h0000, 1, 8'h00, 16'h4001, 0, 16'h0000, 0, 16'd0);
        tv[2]  = mk(0, 16'h0000, 1, 8'h01, 16'h6102, 0, 16'h0000, 0, 16'd0);
        tv[3]  = mk(0, 16'h0000, 1, 8'h02, 16'h9003, 0, 16'h0000, 0, 16'd0);
        // single fetch of 0x05 with LATENCY=2
        tv[4]  = mk(1, 16'h0005, 0, 8'h00, 16'h0000, 0, 16'h0000, 1, 16'd0);
        tv[5]  = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 1, 16'hF01C, 1, 16'd0);
        tv[6]  = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'hF01C, 0, 16'd1);
        // readM held for three fetches, pulses 3 cycles apart
        tv[7]  = mk(1, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'hF01C, 1, 16'd1);
        tv[8]  = mk(1, 16'h0000, 0, 8'h00, 16'h0000, 1, 16'h4001, 1, 16'd1);
        tv[9]  = mk(1, 16'h0001, 0, 8'h00, 16'h0000, 0, 16'h4001, 0, 16'd2);
        tv[10] = mk(1, 16'h0001, 0, 8'h00, 16'h0000, 0, 16'h4001, 1, 16'd2);
        tv[11] = mk(1, 16'h0001, 0, 8'h00, 16'h0000, 1, 16'h6102, 1, 16'd2);
        tv[12] = mk(1, 16'h0002, 0, 8'h00, 16'h0000, 0, 16'h6102, 0, 16'd3);
        tv[13] = mk(1, 16'h0002, 0, 8'h00, 16'h0000, 0, 16'h6102, 1, 16'd3);
        tv[14] = mk(1, 16'h0002, 0, 8'h00, 16'h0000, 1, 16'h9003, 1, 16'd3);
        tv[15] = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'h9003, 0, 16'd4);
        // 0x0105 wraps to index 0x05; address change during WAIT ignored
        tv[16] = mk(1, 16'h0105, 0, 8'h00, 16'h0000, 0, 16'h9003, 1, 16'd4);
        tv[17] = mk(0, 16'h0007, 0, 8'h00, 16'h0000, 1, 16'hF01C, 1, 16'd4);
        tv[18] = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'hF01C, 0, 16'd5);
        // load wins over readM in IDLE, request taken next cycle
        tv[19] = mk(1, 16'h0005, 1, 8'h05, 16'hABCD, 0, 16'hF01C, 0, 16'd5);
        tv[20] = mk(1, 16'h0005, 0, 8'h00, 16'h0000, 0, 16'hF01C, 1, 16'd5);
        // load during WAIT must not write
        tv[21] = mk(0, 16'h0000, 1, 8'h05, 16'h2222, 1, 16'hABCD, 1, 16'd5);
        tv[22] = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'hABCD, 0, 16'd6);
        tv[23] = mk(1, 16'h0005, 0, 8'h00, 16'h0000, 0, 16'hABCD, 1, 16'd6);
        tv[24] = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 1, 16'hABCD, 1, 16'd6);
        tv[25] = mk(0, 16'h0000, 0, 8'h00, 16'h0000, 0, 16'hABCD, 0, 16'd7);

        reset_n = 1'b0;
        bus.readM = 1'b0;  bus.address = '0;
        bus1.readM = 1'b0; bus1.address = '0;
        ld_en = 1'b0;  ld_addr = '0;  ld_data = '0;
        ld1_en = 1'b0; ld1_addr = '0; ld1_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_main("reset", 1'b0, 16'h0000, 1'b0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            bus.readM   = tv[i].rd;
            bus.address = tv[i].addr;
            ld_en       = tv[i].ld;
            ld_addr     = tv[i].laddr;
            ld_data     = tv[i].ldata;
            @(posedge clk);
            #1;
            chk_main($sformatf("vec%0d", i), tv[i].rdy, tv[i].dat, tv[i].bsy, tv[i].cn);
        end

        // reset one cycle after acceptance: outputs clear before any edge
        @(negedge clk);
        bus.readM = 1'b1; bus.address = 16'h0001; ld_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.busy_before", 16'(bus.busy), 16'd1);
        @(negedge clk);
        bus.readM = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_main("abort.async", 1'b0, 16'h0000, 1'b0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_main($sformatf("abort.quiet%0d", i), 1'b0, 16'h0000, 1'b0, 16'd0);
        end
        // next request after reset is served normally; RAM survived reset
        @(negedge clk);
        bus.readM = 1'b1; bus.address = 16'h0001;
        @(posedge clk);
        #1;
        chk_main("post.acc", 1'b0, 16'h0000, 1'b1, 16'd0);
        @(negedge clk);
        bus.readM = 1'b0;
        @(posedge clk);
        #1;
        chk_main("post.resp", 1'b1, 16'h6102, 1'b1, 16'd0);
        @(posedge clk);
        #1;
        chk_main("post.idle", 1'b0, 16'h6102, 1'b0, 16'd1);

        // LATENCY=1 instance: response in the cycle right after acceptance
        @(negedge clk);
        ld1_en = 1'b1; ld1_addr = 8'h03; ld1_data = 16'h1234;
        @(negedge clk);
        ld1_addr = 8'h04; ld1_data = 16'h5678;
        @(negedge clk);
        ld1_en = 1'b0;
        bus1.readM = 1'b1; bus1.address = 16'h0003;
        @(posedge clk);
        #1;
        chk_l1("l1.resp0", 1'b1, 16'h1234, 1'b1, 16'd0);
        @(negedge clk);
        bus1.address = 16'h0004;
        @(posedge clk);
        #1;
        chk_l1("l1.idle0", 1'b0, 16'h1234, 1'b0, 16'd1);
        @(posedge clk);
        #1;
        chk_l1("l1.resp1", 1'b1, 16'h5678, 1'b1, 16'd1);
        @(negedge clk);
        bus1.readM = 1'b0;
        @(posedge clk);
        #1;
        chk_l1("l1.idle1", 1'b0, 16'h5678, 1'b0, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
